// File: rtl/regfile_wb_pkg.sv
// rtl/regfile_wb_pkg.sv - shared types and constants for the register-file write-back arbiter
package regfile_wb_pkg;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef enum logic [1:0] {
        ST_NORMAL = 2'd0,
        ST_HOLD   = 2'd1
    } state_t;

    typedef struct packed {
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order buffer for multi-cycle write-back results
module wb_fifo
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  wb_entry_t                push_data,
    output wb_entry_t                head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/regfile_wb_arb.sv
// rtl/regfile_wb_arb.sv - shares the register-file write port between EX and the multi-cycle unit
module regfile_wb_arb
    import regfile_wb_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid_i,
    input  logic [AW-1:0] ex_waddr_i,
    input  logic [DW-1:0] ex_wdata_i,
    input  logic          mc_valid_i,
    output logic          mc_ready_o,
    input  logic [AW-1:0] mc_waddr_i,
    input  logic [DW-1:0] mc_wdata_i,
    output logic          reg_wen_o,
    output logic [AW-1:0] reg_waddr_o,
    output logic [DW-1:0] reg_wdata_o,
    output logic          hold_o,
    output logic          err_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL_CNT    = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_CNT     = CW'(1);
    localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_MAX - 1);
    localparam logic [SW-1:0] STARVE_SAT  = SW'(STARVE_MAX);

    state_t        state;
    logic [SW-1:0] starve_cnt;
    logic [CW-1:0] count;
    wb_entry_t     head;
    wb_entry_t     sel;
    logic          empty, in_hold, grant_ex, grant_head, bypass, push, slot;

    assign empty   = (count == '0);
    assign in_hold = (state == ST_HOLD);
    assign hold_o  = in_hold;

    // Ready looks only at the registered count, so a full FIFO stays not-ready even while popping.
    assign mc_ready_o = (count < FULL_CNT) & rst;

    assign grant_ex   = ~in_hold & ex_valid_i;
    assign grant_head = ~empty & (in_hold | ~ex_valid_i);
    assign bypass     = ~in_hold & ~ex_valid_i & empty & mc_valid_i & mc_ready_o;
    assign push       = mc_valid_i & mc_ready_o & ~bypass;
    assign slot       = grant_ex | grant_head | bypass;

    always_comb begin
        sel = '0;
        if (grant_ex)        sel = {ex_waddr_i, ex_wdata_i};
        else if (grant_head) sel = head;
        else if (bypass)     sel = {mc_waddr_i, mc_wdata_i};
    end

    // Writes to x0 still consume the slot but never reach the register file.
    assign reg_wen_o   = rst & slot & (sel.waddr != REG_ZERO);
    assign reg_waddr_o = reg_wen_o ? sel.waddr : '0;
    assign reg_wdata_o = reg_wen_o ? sel.wdata : '0;

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (grant_head),
        .push_data ({mc_waddr_i, mc_wdata_i}),
        .head      (head),
        .count     (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_NORMAL;
            starve_cnt <= '0;
            err_o      <= 1'b0;
        end else begin
            if (ex_valid_i && in_hold) err_o <= 1'b1;

            if (empty || grant_head)        starve_cnt <= '0;
            else if (starve_cnt != STARVE_SAT) starve_cnt <= starve_cnt + 1'b1;

            case (state)
                ST_NORMAL: if (!empty && !grant_head && starve_cnt == STARVE_LAST) state <= ST_HOLD;
                ST_HOLD:   if (count == ONE_CNT && grant_head && !push) state <= ST_NORMAL;
                default:   state <= ST_NORMAL;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arb.sv
// tb/tb_regfile_wb_arb.sv - self-checking bench for the write-back arbiter
module tb_regfile_wb_arb;
    import regfile_wb_pkg::*;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, mc_valid, mc_ready, reg_wen, hold, err;
    logic [4:0]  ex_waddr, mc_waddr, reg_waddr;
    logic [31:0] ex_wdata, mc_wdata, reg_wdata;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    regfile_wb_arb #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk         (clk),
        .rst         (rst_n),
        .ex_valid_i  (ex_valid),
        .ex_waddr_i  (ex_waddr),
        .ex_wdata_i  (ex_wdata),
        .mc_valid_i  (mc_valid),
        .mc_ready_o  (mc_ready),
        .mc_waddr_i  (mc_waddr),
        .mc_wdata_i  (mc_wdata),
        .reg_wen_o   (reg_wen),
        .reg_waddr_o (reg_waddr),
        .reg_wdata_o (reg_wdata),
        .hold_o      (hold),
        .err_o       (err)
    );

    typedef struct {
        logic ev; logic [4:0] ea; logic [31:0] ed;
        logic mv; logic [4:0] ma; logic [31:0] md;
        logic w;  logic [4:0] a;  logic [31:0] d;  logic rdy;
    } vec_t;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    vec_t tbl [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_now(input string name, input logic w, input logic [4:0] a, input logic [31:0] d,
                             input logic rdy, input logic h, input logic e);
        chk({name, ".wen"},   32'(reg_wen),   32'(w));
        chk({name, ".waddr"}, 32'(reg_waddr), 32'(a));
        chk({name, ".wdata"}, reg_wdata,      d);
        chk({name, ".ready"}, 32'(mc_ready),  32'(rdy));
        chk({name, ".hold"},  32'(hold),      32'(h));
        chk({name, ".err"},   32'(err),       32'(e));
    endtask

    task automatic drive(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                         input logic mv, input logic [4:0] ma, input logic [31:0] md);
        ex_valid = ev; ex_waddr = ea; ex_wdata = ed;
        mc_valid = mv; mc_waddr = ma; mc_wdata = md;
    endtask

    task automatic expect_out(input string name, input logic w, input logic [4:0] a, input logic [31:0] d,
                              input logic rdy, input logic h, input logic e);
        @(negedge clk);
        check_now(name, w, a, d, rdy, h, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        ent_t q[$];
        bit   m_hold, m_err;
        int   m_starve, p;
        int   probs [4] = '{10, 50, 90, 100};

        tbl[0] = '{1'b0, 5'd0, 32'h0,  1'b1, 5'd5, 32'hA5A5A5A5, 1'b1, 5'd5, 32'hA5A5A5A5, 1'b1};
        tbl[1] = '{1'b1, 5'd3, 32'h1,  1'b1, 5'd4, 32'h2,        1'b1, 5'd3, 32'h1,        1'b1};
        tbl[2] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b1, 5'd4, 32'h2,        1'b1};
        tbl[3] = '{1'b1, 5'd0, 32'h7,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1};
        tbl[4] = '{1'b1, 5'd1, 32'hB,  1'b1, 5'd0, 32'h55,       1'b1, 5'd1, 32'hB,        1'b1};
        tbl[5] = '{1'b1, 5'd2, 32'h16, 1'b1, 5'd6, 32'h42,       1'b1, 5'd2, 32'h16,       1'b1};
        tbl[6] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1};
        tbl[7] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b1, 5'd6, 32'h42,       1'b1};
        tbl[8] = '{1'b0, 5'd0, 32'h0,  1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b1};

        // Reset held with random traffic: everything must read zero.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b1, 5'($urandom_range(1, 31)), $urandom);
            expect_out("reset", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        #1;
        chk("release.ready", 32'(mc_ready), 32'd1);
        chk("release.hold",  32'(hold),     32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].ev, tbl[i].ea, tbl[i].ed, tbl[i].mv, tbl[i].ma, tbl[i].md);
            expect_out($sformatf("tbl%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rdy, 1'b0, 1'b0);
        end

        // Full FIFO under continuous EX, then a pop cycle that must not reopen ready.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 5'd1, 32'h100 + i, 1'b1, 5'(10 + i), 32'h200 + i);
            expect_out($sformatf("full.push%0d", i), 1'b1, 5'd1, 32'h100 + i, i < 4, 1'b0, 1'b0);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_out("full.pop", 1'b1, 5'd10, 32'h200, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 3; j++)
            expect_out($sformatf("full.drain%0d", j), 1'b1, 5'(11 + j), 32'h201 + j, 1'b1, 1'b0, 1'b0);
        expect_out("full.empty", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Starvation: one queued entry under continuous EX forces HOLD.
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd9, 32'h99);
        expect_out("starve.enq", 1'b1, 5'd1, 32'h11, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= STARVE_MAX; i++) begin
            drive(1'b1, 5'd2, 32'h20 + i, 1'b0, 5'd0, 32'h0);
            expect_out($sformatf("starve.c%0d", i), 1'b1, 5'd2, 32'h20 + i, 1'b1, 1'b0, 1'b0);
        end
        drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'h0);
        expect_out("starve.hold", 1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_out("starve.exit", 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1);

        // Fill, reach HOLD, then reset asynchronously with three entries still queued.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd1, 32'h40 + i, 1'b1, 5'(20 + i), 32'h300 + i);
            expect_out($sformatf("mid.enq%0d", i), 1'b1, 5'd1, 32'h40 + i, 1'b1, 1'b0, 1'b1);
        end
        for (int i = 4; i <= STARVE_MAX; i++) begin
            drive(1'b1, 5'd1, 32'h40 + i, 1'b0, 5'd0, 32'h0);
            expect_out($sformatf("mid.c%0d", i), 1'b1, 5'd1, 32'h40 + i, 1'b0, 1'b0, 1'b1);
        end
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_out("mid.hold0", 1'b1, 5'd20, 32'h300, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        check_now("mid.hold1", 1'b1, 5'd21, 32'h301, 1'b1, 1'b1, 1'b1);
        #2;
        drive(1'b1, 5'd7, 32'hDEAD, 1'b1, 5'd8, 32'hBEEF);
        rst_n = 1'b0;
        #1;
        check_now("mid.rst", 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++)
            expect_out($sformatf("mid.after%0d", i), 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Randomized traffic against a queue-based reference model.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        m_hold = 0; m_err = 0; m_starve = 0; p = 50;
        for (int c = 0; c < 3000; c++) begin
            ent_t slot;
            bit   has, popped, byp, rdy, nonempty, ev, mv, w;
            logic [4:0]  ea, ma;
            logic [31:0] ed, md;
            if (c % 150 == 0) p = probs[$urandom_range(0, 3)];
            ev = ($urandom_range(0, 99) < p);
            if (m_hold && $urandom_range(0, 15) != 0) ev = 0;
            mv = ($urandom_range(0, 99) < 60);
            ea = 5'($urandom_range(0, 31)); ed = $urandom;
            ma = 5'($urandom_range(0, 31)); md = $urandom;
            drive(ev, ea, ed, mv, ma, md);
            @(negedge clk);

            has = 0; popped = 0; byp = 0; slot = '0;
            rdy = (q.size() < DEPTH);
            nonempty = (q.size() != 0);
            if (m_hold) begin
                slot = q[0]; has = 1; popped = 1;
            end else if (ev) begin
                slot = '{ea, ed}; has = 1;
            end else if (nonempty) begin
                slot = q[0]; has = 1; popped = 1;
            end else if (mv) begin
                slot = '{ma, md}; has = 1; byp = 1;
            end
            w = has && (slot.a != 5'd0);
            check_now($sformatf("rnd%0d", c), w, w ? slot.a : 5'd0, w ? slot.d : 32'h0, rdy, m_hold, m_err);

            if (m_hold && ev) m_err = 1;
            if (popped) void'(q.pop_front());
            if (mv && rdy && !byp) q.push_back('{ma, md});
            m_starve = (nonempty && !popped) ? m_starve + 1 : 0;
            if (!m_hold && m_starve >= STARVE_MAX) m_hold = 1;
            else if (m_hold && q.size() == 0)      m_hold = 0;

            @(posedge clk);
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
